opsum_pack_fifo: RTL and testbench

//  Parametrised partial-sum FIFO for the CONV unit, between PE opsum outputs and the opsum write-back packer.

---
 rtl/opsum_pack_fifo.sv | 127 ++++++++++++
 tb/tb_opsum_pack_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/opsum_pack_fifo.sv
// Partial-sum FIFO between PE opsum outputs and the write-back packer: 1 psum in, 1..PACK psums out lane-packed.
// Latency: a push is visible to pop the cycle after it is written; pop_data/pop_ready are combinational show-ahead.
// Backpressure: pushes are dropped while full (ovf_err), pops wider than the level are refused whole (udf_err).
module opsum_pack_fifo #(
    parameter int W         = 16,
    parameter int DEPTH     = 8,
    parameter int PACK      = 2,
    parameter int AF_THRESH = 6,
    localparam int LEN_W    = $clog2(PACK),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_en,
    input  logic [W-1:0]      push_data,
    output logic              full,
    output logic              almost_full,
    input  logic              pop_en,
    input  logic [LEN_W-1:0]  pop_len,
    output logic              pop_ready,
    output logic [W*PACK-1:0] pop_data,
    output logic              empty,
    output logic [CNT_W-1:0]  level,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is intentionally left unreset; level/pointers alone define validity.
    logic [W-1:0]     mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             ovf_err_q, ovf_err_d;
    logic             udf_err_q, udf_err_d;

    logic [CNT_W-1:0] pop_cnt;
    logic             push_acc;
    logic             pop_acc;

    // Status decode from the registered level only, so these never glitch on inputs.
    always_comb begin
        level       = level_q;
        empty       = (level_q == '0);
        full        = (level_q == CNT_W'(DEPTH));
        almost_full = (level_q >= CNT_W'(AF_THRESH));
        ovf_err     = ovf_err_q;
        udf_err     = udf_err_q;
    end

    // Pop handshake: a pop is all-or-nothing, sized by pop_len+1.
    always_comb begin
        pop_cnt   = CNT_W'(pop_len) + CNT_W'(1);
        pop_ready = (level_q >= pop_cnt);
        push_acc  = push_en && !full && !flush;
        pop_acc   = pop_en && pop_ready && !flush;
    end

    // Show-ahead packing: oldest entry in lane 0, unused lanes forced to zero.
    always_comb begin
        pop_data = '0;
        if (pop_en && pop_ready) begin
            for (int i = 0; i < PACK; i++) begin
                if (i <= int'(pop_len)) begin
                    pop_data[i*W +: W] = mem_q[rd_ptr_q + PTR_W'(i)];
                end
            end
        end
    end

    // Next-state: flush clears occupancy but keeps the sticky error flags.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        ovf_err_d = ovf_err_q;
        udf_err_d = udf_err_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en && full) begin
                ovf_err_d = 1'b1;
            end
            if (pop_en && !pop_ready) begin
                udf_err_d = 1'b1;
            end
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                // Power-of-two depth makes the natural pointer wrap the modulo.
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
            end
            level_d = level_q + CNT_W'(push_acc) - (pop_acc ? pop_cnt : CNT_W'(0));
        end
    end

    // Control registers with synchronous reset (reset wins over flush).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    // Storage write on accepted push; suppressed during reset so a held push leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_opsum_pack_fifo.sv
module tb_opsum_pack_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push_en;
    logic [15:0] push_data;
    logic        full;
    logic        almost_full;
    logic        pop_en;
    logic [0:0]  pop_len;
    logic        pop_ready;
    logic [31:0] pop_data;
    logic        empty;
    logic [3:0]  level;
    logic        ovf_err;
    logic        udf_err;

    opsum_pack_fifo #(.W(16), .DEPTH(8), .PACK(2), .AF_THRESH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push_en     (push_en),
        .push_data   (push_data),
        .full        (full),
        .almost_full (almost_full),
        .pop_en      (pop_en),
        .pop_len     (pop_len),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .empty       (empty),
        .level       (level),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is just an ordered queue plus two sticky bits.
    logic [15:0] q[$];
    logic        m_ovf;
    logic        m_udf;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_pd;
    logic        last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check combinational pop side, clock, update model, check registered side.
    task automatic step(input logic pe, input logic [15:0] pd, input logic oe, input logic pl,
                        input logic fl, input logic rs);
        logic [31:0] e_pd;
        logic        e_rdy;
        int          n_pop;
        bit          do_push;
        @(negedge clk);
        push_en   = pe;
        push_data = pd;
        pop_en    = oe;
        pop_len   = pl;
        flush     = fl;
        rst       = rs;
        #1;
        n_pop = int'(pl) + 1;
        e_rdy = (q.size() >= n_pop);
        e_pd  = '0;
        if (oe && e_rdy) begin
            for (int i = 0; i < n_pop; i++) e_pd[i*16 +: 16] = q[i];
        end
        last_pd  = pop_data;
        last_rdy = pop_ready;
        chk("pop_ready", {63'd0, pop_ready}, {63'd0, e_rdy});
        chk("pop_data", {32'd0, pop_data}, {32'd0, e_pd});
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            do_push = pe && (q.size() < 8);
            if (pe && q.size() == 8) m_ovf = 1'b1;
            if (oe && !e_rdy) m_udf = 1'b1;
            if (oe && e_rdy) begin
                for (int i = 0; i < n_pop; i++) void'(q.pop_front());
            end
            if (do_push) q.push_back(pd);
        end
        #1;
        chk("level", {60'd0, level}, 64'(q.size()));
        chk("empty", {63'd0, empty}, {63'd0, q.size() == 0});
        chk("full", {63'd0, full}, {63'd0, q.size() == 8});
        chk("almost_full", {63'd0, almost_full}, {63'd0, q.size() >= 6});
        chk("ovf_err", {63'd0, ovf_err}, {63'd0, m_ovf});
        chk("udf_err", {63'd0, udf_err}, {63'd0, m_udf});
    endtask

    task automatic push(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic pl);
        step(1'b0, 16'h0, 1'b1, pl, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_en = 1'b0; push_data = '0; pop_en = 1'b0; pop_len = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pop_data", {32'd0, last_pd}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);

        // Basic pack order
        push(16'h0001); push(16'h0002); push(16'h0003);
        pop(1'b1);
        chk("s1_pack2", {32'd0, last_pd}, 64'h0002_0001);
        chk("s1_level", {60'd0, level}, 64'd1);
        pop(1'b0);
        chk("s1_pack1", {32'd0, last_pd}, 64'h0000_0003);
        chk("s1_empty", {63'd0, empty}, 64'd1);

        // Fill to full, then push+pop at full drops the push
        for (int i = 0; i < 8; i++) begin
            push(16'h0010 + 16'(i));
            if (i == 4) chk("s2_af_lo", {63'd0, almost_full}, 64'd0);
            if (i == 5) chk("s2_af_hi", {63'd0, almost_full}, 64'd1);
        end
        chk("s2_full", {63'd0, full}, 64'd1);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s2_level", {60'd0, level}, 64'd6);
        chk("s2_ovf", {63'd0, ovf_err}, 64'd1);

        // Underflow: two-wide pop at level 1 is refused whole
        pop(1'b1); pop(1'b1); pop(1'b0);
        pop(1'b1);
        chk("s3_ready", {63'd0, last_rdy}, 64'd0);
        chk("s3_pd", {32'd0, last_pd}, 64'd0);
        chk("s3_level", {60'd0, level}, 64'd1);
        chk("s3_udf", {63'd0, udf_err}, 64'd1);

        // Wraparound across slot 7 -> 0
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) push(16'h0100 + 16'(i));
        for (int i = 0; i < 7; i++) pop(1'b0);
        push(16'hAAAA); push(16'hBBBB);
        pop(1'b1);
        chk("s4_wrap", {32'd0, last_pd}, 64'hBBBB_AAAA);

        // Simultaneous push and pop
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i));
        step(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s5_net_m1", {60'd0, level}, 64'd3);
        step(1'b1, 16'h0301, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s5_net_0", {60'd0, level}, 64'd3);
        chk("s5_order", {32'd0, last_pd}, 64'h0000_0202);

        // Flush with a push pending, then reset mid-burst
        push(16'h0400); push(16'h0401);
        step(1'b1, 16'h0402, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s6_flush_lvl", {60'd0, level}, 64'd0);
        chk("s6_flush_ovf", {63'd0, ovf_err}, 64'd0);
        push(16'h0500); push(16'h0501);
        step(1'b1, 16'h0502, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("s6_rst_empty", {63'd0, empty}, 64'd1);
        chk("s6_rst_udf", {63'd0, udf_err}, 64'd0);

        // Randomised traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 60), 16'($urandom),
                 ($urandom_range(0, 99) < 50), 1'($urandom),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
